// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between the client blocks and the shared multiplier arbiter.
// The master side belongs to the requesters and the slave side belongs to the arbiter.
interface mul_share_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [8*NREQ-1:0]  req_a;
    logic [8*NREQ-1:0]  req_b;
    logic [NREQ-1:0]    resp_valid;
    logic [NREQ-1:0]    resp_ready;
    logic [16*NREQ-1:0] resp_p;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_p
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// One signed 8x8 Wallace multiplier shared round-robin among NREQ requesters.
// Each requester has a one-entry result slot. The pipeline is two stages and never stalls.
module wallace (
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    output logic signed [15:0] p
);
    logic [15:0] a_ext;
    logic [15:0] pp [9];
    logic [15:0] l1 [6];
    logic [15:0] l2 [4];
    logic [15:0] l3 [3];
    logic [15:0] l4 [2];

    assign a_ext = {{8{a[7]}}, a};

    // Row 7 carries weight -128, so it is added as the inverted row plus one in pp[8].
    for (genvar gi = 0; gi < 7; gi++) begin : g_pp
        assign pp[gi] = b[gi] ? (a_ext << gi) : 16'd0;
    end
    assign pp[7] = b[7] ? ~(a_ext << 7) : 16'd0;
    assign pp[8] = {15'd0, b[7]};

    for (genvar gi = 0; gi < 3; gi++) begin : g_l1
        assign l1[2*gi]   = pp[3*gi] ^ pp[3*gi+1] ^ pp[3*gi+2];
        assign l1[2*gi+1] = ((pp[3*gi] & pp[3*gi+1]) | (pp[3*gi] & pp[3*gi+2])
                            | (pp[3*gi+1] & pp[3*gi+2])) << 1;
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_l2
        assign l2[2*gi]   = l1[3*gi] ^ l1[3*gi+1] ^ l1[3*gi+2];
        assign l2[2*gi+1] = ((l1[3*gi] & l1[3*gi+1]) | (l1[3*gi] & l1[3*gi+2])
                            | (l1[3*gi+1] & l1[3*gi+2])) << 1;
    end

    assign l3[0] = l2[0] ^ l2[1] ^ l2[2];
    assign l3[1] = ((l2[0] & l2[1]) | (l2[0] & l2[2]) | (l2[1] & l2[2])) << 1;
    assign l3[2] = l2[3];
    assign l4[0] = l3[0] ^ l3[1] ^ l3[2];
    assign l4[1] = ((l3[0] & l3[1]) | (l3[0] & l3[2]) | (l3[1] & l3[2])) << 1;
    assign p     = l4[0] + l4[1];
endmodule

module mul_share_arbiter #(
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst,
    mul_share_arbiter_if.slave  bus,
    output logic [NREQ-1:0]     busy,
    output logic [CNTW-1:0]     ops_done
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SUMW = CNTW + 5;
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    logic [7:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d, last_q, last_d;
    logic            s1_v_q, s1_v_d;
    logic [NREQ-1:0] busy_q, busy_d, resp_valid_q, resp_valid_d;
    logic [15:0]     p_q [NREQ];
    logic [15:0]     p_d [NREQ];
    logic [CNTW-1:0] ops_done_q, ops_done_d;

    logic [NREQ-1:0] elig, grant, hs;
    logic            grant_any;
    logic [IDW-1:0]  grant_id;
    logic [3:0]      hs_cnt;
    logic [SUMW-1:0] ops_sum;
    logic signed [15:0] product;
    int              idx;

    wallace u_mul (.a(s1_a_q), .b(s1_b_q), .p(product));

    assign elig = bus.req_valid & ~busy_q & {NREQ{~rst}};
    assign hs   = resp_valid_q & bus.resp_ready;

    // Search starts just after the last winner, so the last winner has lowest priority.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = last_q;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            if (!grant_any && elig[idx]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
        if (grant_any) grant[grant_id] = 1'b1;
    end

    always_comb begin
        s1_v_d  = grant_any;
        s1_a_d  = grant_any ? bus.req_a[8*int'(grant_id) +: 8] : s1_a_q;
        s1_b_d  = grant_any ? bus.req_b[8*int'(grant_id) +: 8] : s1_b_q;
        s1_id_d = grant_any ? grant_id : s1_id_q;
        last_d  = grant_any ? grant_id : last_q;
        hs_cnt  = '0;
        for (int i = 0; i < NREQ; i++) begin
            busy_d[i]       = grant[i] | (busy_q[i] & ~hs[i]);
            resp_valid_d[i] = (s1_v_q && s1_id_q == IDW'(i)) | (resp_valid_q[i] & ~hs[i]);
            p_d[i]          = (s1_v_q && s1_id_q == IDW'(i)) ? product : p_q[i];
            hs_cnt          = hs_cnt + 4'(hs[i]);
        end
        ops_sum = SUMW'(ops_done_q) + SUMW'(hs_cnt);
        ops_done_d = (ops_sum > SUMW'({CNTW{1'b1}})) ? {CNTW{1'b1}} : ops_sum[CNTW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_id_q      <= '0;
            s1_v_q       <= 1'b0;
            last_q       <= LAST_RST;
            busy_q       <= '0;
            resp_valid_q <= '0;
            ops_done_q   <= '0;
            for (int i = 0; i < NREQ; i++) p_q[i] <= '0;
        end else begin
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_id_q      <= s1_id_d;
            s1_v_q       <= s1_v_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            ops_done_q   <= ops_done_d;
            for (int i = 0; i < NREQ; i++) p_q[i] <= p_d[i];
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
        assign bus.resp_p[16*gi +: 16] = p_q[gi];
    end
    assign bus.req_ready  = grant;
    assign bus.resp_valid = resp_valid_q;
    assign busy           = busy_q;
    assign ops_done       = ops_done_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: one task per scenario, with hand-computed expectations.
// Inputs are driven on the falling edge, and outputs are sampled 1 time unit later.
module tb_mul_share_arbiter;
    localparam int NREQ = 4;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] busy;
    logic [CNTW-1:0] ops_done;
    int total = 0;
    int bad = 0;

    mul_share_arbiter_if #(.NREQ(NREQ)) bus ();

    mul_share_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .ops_done (ops_done)
    );

    always #5 clk = ~clk;

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[8*i +: 8] = a;
        bus.req_b[8*i +: 8] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid  = '1;
        bus.resp_ready = '1;
        #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b want=0000", bus.req_ready); end
        @(negedge clk); #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready2 got=%b want=0000", bus.req_ready); end
        total++; if (bus.resp_valid !== 4'b0000) begin bad++; $display("FAIL rst_resp_valid got=%b want=0000", bus.resp_valid); end
        total++; if (busy !== 4'b0000) begin bad++; $display("FAIL rst_busy got=%b want=0000", busy); end
        total++; if (ops_done !== 4'd0) begin bad++; $display("FAIL rst_ops_done got=%0d want=0", ops_done); end
        total++; if (bus.resp_p !== 64'd0) begin bad++; $display("FAIL rst_resp_p got=%h want=0", bus.resp_p); end
        rst = 1'b0;
        bus.req_valid = '0;
        $display("reset: ready=%b resp_valid=%b busy=%b ops=%0d", bus.req_ready, bus.resp_valid, busy, ops_done);
    endtask

    task automatic test_single();
        do_reset();
        set_ops(0, 8'd3, 8'd5);
        bus.resp_ready = '1;
        bus.req_valid  = 4'b0001;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        total++; if (bus.resp_valid !== 4'b0000) begin bad++; $display("FAIL single_early got=%b want=0000", bus.resp_valid); end
        total++; if (busy !== 4'b0001) begin bad++; $display("FAIL single_busy got=%b want=0001", busy); end
        @(negedge clk); #1;
        total++; if (bus.resp_valid !== 4'b0001) begin bad++; $display("FAIL single_valid got=%b want=0001", bus.resp_valid); end
        total++; if (bus.resp_p[15:0] !== 16'h000F) begin bad++; $display("FAIL single_p got=%h want=000f", bus.resp_p[15:0]); end
        $display("single: r0 3*5 p=%h", bus.resp_p[15:0]);
        @(negedge clk); #1;
        total++; if (bus.resp_valid !== 4'b0000) begin bad++; $display("FAIL single_clear got=%b want=0000", bus.resp_valid); end
        total++; if (busy !== 4'b0000) begin bad++; $display("FAIL single_idle got=%b want=0000", busy); end
        total++; if (ops_done !== 4'd1) begin bad++; $display("FAIL single_ops got=%0d want=1", ops_done); end
    endtask

    task automatic test_signed();
        logic [7:0]  ta [3] = '{8'h80, 8'h80, 8'hFF};
        logic [7:0]  tb [3] = '{8'h80, 8'h7F, 8'h01};
        logic [15:0] tp [3] = '{16'h4000, 16'hC080, 16'hFFFF};
        int          tr [3] = '{1, 2, 3};
        logic [NREQ-1:0] oh;
        do_reset();
        bus.resp_ready = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            oh = '0;
            oh[tr[k]] = 1'b1;
            set_ops(tr[k], ta[k], tb[k]);
            bus.req_valid = oh;
            #1;
            total++; if (bus.req_ready !== oh) begin bad++; $display("FAIL signed_grant%0d got=%b want=%b", k, bus.req_ready, oh); end
            @(negedge clk);
            bus.req_valid = '0;
            @(negedge clk); #1;
            total++; if (bus.resp_valid !== oh) begin bad++; $display("FAIL signed_valid%0d got=%b want=%b", k, bus.resp_valid, oh); end
            total++; if (bus.resp_p[16*tr[k] +: 16] !== tp[k]) begin bad++; $display("FAIL signed_p%0d got=%h want=%h", k, bus.resp_p[16*tr[k] +: 16], tp[k]); end
            $display("signed: r%0d %h*%h p=%h", tr[k], ta[k], tb[k], bus.resp_p[16*tr[k] +: 16]);
            @(negedge clk); #1;
            total++; if (ops_done !== 4'(k + 1)) begin bad++; $display("FAIL signed_ops%0d got=%0d want=%0d", k, ops_done, k + 1); end
        end
    endtask

    task automatic test_fairness();
        int          gseq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [15:0] fp [4]   = '{16'hFFFE, 16'hFFFA, 16'hFFF4, 16'hFFEC};
        logic [NREQ-1:0] oh;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i + 2), 8'(-(i + 1)));
        bus.resp_ready = '1;
        bus.req_valid  = '1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            oh = '0;
            oh[gseq[c]] = 1'b1;
            total++; if (bus.req_ready !== oh) begin bad++; $display("FAIL rr_grant_c%0d got=%b want=%b", c, bus.req_ready, oh); end
            if (c >= 2) begin
                oh = '0;
                oh[gseq[c-2]] = 1'b1;
                total++; if (bus.resp_valid !== oh) begin bad++; $display("FAIL rr_valid_c%0d got=%b want=%b", c, bus.resp_valid, oh); end
                total++; if (bus.resp_p[16*gseq[c-2] +: 16] !== fp[gseq[c-2]]) begin
                    bad++; $display("FAIL rr_p_c%0d got=%h want=%h", c, bus.resp_p[16*gseq[c-2] +: 16], fp[gseq[c-2]]);
                end
            end
            $display("rr: cycle %0d ready=%b resp_valid=%b", c, bus.req_ready, bus.resp_valid);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rr_idle got=%b want=0000", bus.req_ready); end
        @(negedge clk); @(negedge clk); @(negedge clk); #1;
        total++; if (ops_done !== 4'd8) begin bad++; $display("FAIL rr_ops got=%0d want=8", ops_done); end
    endtask

    task automatic test_backpressure();
        int gseq [12] = '{0, 1, 2, 3, 0, 2, 3, 0, 2, 3, 0, 1};
        logic [NREQ-1:0] oh;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i + 1), 8'd2);
        set_ops(1, 8'd7, 8'hF7);
        bus.resp_ready = 4'b1101;
        bus.req_valid  = '1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 10) bus.resp_ready = '1;
            #1;
            oh = '0;
            oh[gseq[c]] = 1'b1;
            total++; if (bus.req_ready !== oh) begin bad++; $display("FAIL bp_grant_c%0d got=%b want=%b", c, bus.req_ready, oh); end
            if (c >= 3 && c <= 10) begin
                total++; if (bus.resp_valid[1] !== 1'b1) begin bad++; $display("FAIL bp_hold_c%0d got=%b want=1", c, bus.resp_valid[1]); end
                total++; if (bus.resp_p[31:16] !== 16'hFFC1) begin bad++; $display("FAIL bp_p_c%0d got=%h want=ffc1", c, bus.resp_p[31:16]); end
            end
            if (c == 11) begin
                total++; if (bus.resp_valid[1] !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", bus.resp_valid[1]); end
            end
            $display("bp: cycle %0d ready=%b resp_valid=%b", c, bus.req_ready, bus.resp_valid);
        end
        @(negedge clk);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.resp_ready = '0;
        bus.req_valid  = 4'b1100;
        #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL mf_grant2 got=%b want=0100", bus.req_ready); end
        @(negedge clk); #1;
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL mf_grant3 got=%b want=1000", bus.req_ready); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL mf_rst_ready got=%b want=0000", bus.req_ready); end
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = '1;
        #1;
        total++; if (busy !== 4'b0000) begin bad++; $display("FAIL mf_busy got=%b want=0000", busy); end
        total++; if (ops_done !== 4'd0) begin bad++; $display("FAIL mf_ops got=%0d want=0", ops_done); end
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mf_first got=%b want=0001", bus.req_ready); end
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) bus.req_valid = '0;
            #1;
            total++; if (bus.resp_valid[3:2] !== 2'b00) begin bad++; $display("FAIL mf_ghost_c%0d got=%b want=00", c, bus.resp_valid[3:2]); end
        end
        $display("midflight: resp_valid=%b busy=%b ops=%0d", bus.resp_valid, busy, ops_done);
    endtask

    task automatic test_saturation();
        int exp_ops;
        do_reset();
        bus.resp_ready = '1;
        bus.req_valid  = '1;
        for (int c = 0; c < 25; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 20) bus.req_valid = '0;
            #1;
            exp_ops = (c < 2) ? 0 : ((c - 2 > 20) ? 20 : c - 2);
            if (exp_ops > 15) exp_ops = 15;
            total++; if (ops_done !== 4'(exp_ops)) begin bad++; $display("FAIL sat_c%0d got=%0d want=%0d", c, ops_done, exp_ops); end
        end
        $display("sat: ops_done=%0d after 20 completions", ops_done);
        // Batched responses: four handshakes on one edge per round.
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            bus.req_valid  = '1;
            bus.resp_ready = '0;
            repeat (3) @(negedge clk);
            @(negedge clk);
            bus.req_valid = '0;
            @(negedge clk); #1;
            total++; if (bus.resp_valid !== 4'b1111) begin bad++; $display("FAIL batch_valid_r%0d got=%b want=1111", r, bus.resp_valid); end
            bus.resp_ready = '1;
            @(negedge clk); #1;
            exp_ops = (4 * r > 15) ? 15 : 4 * r;
            total++; if (ops_done !== 4'(exp_ops)) begin bad++; $display("FAIL batch_ops_r%0d got=%0d want=%0d", r, ops_done, exp_ops); end
            total++; if (bus.resp_valid !== 4'b0000) begin bad++; $display("FAIL batch_clear_r%0d got=%b want=0000", r, bus.resp_valid); end
            $display("batch: round %0d ops_done=%0d", r, ops_done);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = '0;
        test_reset();
        test_single();
        test_signed();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Shares one combinational 8x8 signed Wallace multiplier (`wallace`) among NREQ independent requesters. Arbitration is round-robin. The block registers the granted operands and the product, and keeps a one-entry result slot per requester. Each requester has a valid/ready request channel and a valid/ready response channel. It sits between client blocks and the multiplier so that one tree serves all clients, with one issue per cycle.

## Interface
- NREQ, 4, number of requesters; supported range 2..8.
- CNTW, 16, width of the completed-operation counter.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i presents operands.
- req_ready  out  NREQ  one-hot grant; requester i's operands accepted this cycle.
- req_a  in  8*NREQ  signed multiplicand; requester i uses bits [8i+7:8i].
- req_b  in  8*NREQ  signed multiplier; requester i uses bits [8i+7:8i].
- resp_valid  out  NREQ  result slot i holds a product.
- resp_ready  in  NREQ  requester i consumes its result.
- resp_p  out  16*NREQ  signed product for requester i in bits [16i+15:16i]; stable while resp_valid[i]=1.
- busy  out  NREQ  requester i has an operation in flight or an unconsumed result.
- ops_done  out  CNTW  saturating count of completed response handshakes.

## Operation
- Per-requester state: busy[i], resp_valid[i], product register P[i].
- Pipeline state:
  - stage-1 register S1 = {a, b, id, v}.
  - round-robin pointer last (log2 NREQ bits).
- Eligibility: elig[i] = req_valid[i] & ~busy[i] & ~rst.
- Grant search:
  - Search elig starting at index last+1 mod NREQ, upward with wrap.
  - The first set bit wins. Only that bit of req_ready is asserted.
  - req_ready is combinational from req_valid and registered state.
  - No eligible requester: req_ready = 0 and last is unchanged.
- On a grant to g at edge E0:
  - S1 <= {a_g, b_g, g, 1}.
  - busy[g] <= 1.
  - last <= g.
  - When nothing is granted, S1.v <= 0.
- Multiply:
  - S1.a and S1.b drive the multiplier combinationally.
  - Two's-complement 8x8 -> 16-bit signed product; full range, no overflow.
- Completion at edge E1, when S1.v = 1:
  - P[S1.id] <= product.
  - resp_valid[S1.id] <= 1.
- Response handshake, when resp_valid[i] & resp_ready[i] at an edge:
  - resp_valid[i] <= 0 and busy[i] <= 0.
  - ops_done increments, saturating at all-ones.
  - resp_p[i] keeps its last value after the handshake; it is only meaningful while resp_valid[i]=1.
- Several responses on the same edge: ops_done adds the number of handshakes, saturating.
- Each requester has at most one outstanding operation, so the result slot can never be overwritten.
- The pipeline never stalls. A blocked response only removes that requester from arbitration.
- Reset values:
  - req_ready = 0 (forced while rst=1).
  - resp_valid = 0, busy = 0, ops_done = 0.
  - S1.v = 0, last = NREQ-1, so requester 0 has first priority.
  - P and resp_p = 0.
- Reset mid-operation: in-flight S1 contents and pending results are discarded. No response is ever produced for them.

## Timing
- Request-to-response latency:
  - Accept edge E0.
  - resp_valid visible in the cycle after E1 = E0+1, i.e. 2 cycles from the cycle req_ready was high.
- Throughput: one grant per cycle across all requesters.
- Per-requester re-issue:
  - busy clears at the response handshake edge.
  - The earliest next grant to that requester is the cycle after the handshake.
  - Minimum per-requester period is 3 cycles when resp_ready is held high.
- Simultaneous events:
  - A grant to one requester, a completion into another requester's slot, and a response handshake on a third can all occur on the same edge.
  - All of these are independent.
- A requester deasserting req_valid before it is granted is legal; no state changes.
- Critical path: the S1 register through the multiplier into P. Do not add input-side combinational logic before S1.

## Test plan
- Single request:
  - Stimulus: requester 0, a=3, b=5; resp_ready held high.
  - Expected: req_ready[0]=1 in cycle 0; resp_valid[0]=1 in cycle 2 with resp_p[0]=0x000F; ops_done=1 after the handshake.
- Signed extremes:
  - Stimulus: (-128)*(-128), then (-128)*127, then (-1)*1.
  - Expected: 0x4000, 0xC080 and 0xFFFF respectively.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high, resp_ready high.
  - Expected: grants 0,1,2,3 in consecutive cycles, then 0 again once busy[0] clears (cycle 4); never two grants in one cycle.
- Response backpressure:
  - Stimulus: resp_ready[1]=0 for 10 cycles with all requesters active.
  - Expected: requester 1 is granted once; resp_valid[1] and resp_p[1] stay stable; requesters 0, 2 and 3 keep cycling; requester 1 is re-granted the cycle after resp_ready[1] rises.
- Reset mid-flight:
  - Stimulus: assert rst for 1 cycle immediately after grants to requesters 2 and 3.
  - Expected: no resp_valid ever rises for those operations; busy=0 and ops_done=0 after reset; the first post-reset grant goes to requester 0 when all are valid.
- Counter saturation:
  - Stimulus: CNTW=4 with 20 completions.
  - Expected: ops_done stops at 0xF.
